param_shift_packer: RTL

Parametrised serial-in/parallel-out packer that generalises the fixed-ratio shift registers (8→64, 6→96, 12→96, 48→96) into one block. It accepts IN_W-bit chunks over a valid/ready handshake, assembles them into OUT_W-bit words, and presents each completed word on a held output with its own valid/ready handshake. It supports early termination with zero padding, selectable chunk ordering and a flush. It sits between the matrix-entry input path and the operand registers of the calculator datapath.

---
 rtl/param_shift_packer.sv | 99 +++++++++
 1 files changed

// File: rtl/param_shift_packer.sv
// Serial-in/parallel-out packer: gathers IN_W-bit chunks into OUT_W-bit words and holds
// each finished word until the consumer takes it.
module param_shift_packer #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 96,
  parameter bit MSB_FIRST = 1'b1,
  localparam int N        = OUT_W / IN_W,
  localparam int CW       = $clog2(N + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a held word stays stable until it is accepted.

  if (((OUT_W % IN_W) != 0) || ((OUT_W / IN_W) < 2)) begin : g_bad_cfg
    $error("param_shift_packer: OUT_W must be a multiple of IN_W with at least 2 chunks");
  end

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] data_q;
  logic [CW-1:0]    count_q;
  logic             last_q;

  logic [OUT_W-1:0] ins_base;
  logic [OUT_W-1:0] ins_data;
  logic [CW-1:0]    ins_idx;
  logic [CW-1:0]    next_count;
  logic             full;
  logic             accept;
  logic             release_word;

  assign in_ready     = rst_n & ~flush & ((state == FILL) | out_ready);
  assign accept       = in_valid & in_ready;
  assign release_word = (state == HOLD) & out_ready;

  // A chunk taken while a word is being released starts the next word in slot 0.
  always_comb begin
    ins_base = (state == FILL) ? data_q : '0;
    ins_idx  = (state == FILL) ? count_q : '0;
    ins_data = ins_base;
    for (int i = 0; i < N; i++) begin
      if (ins_idx == CW'(i)) begin
        ins_data[(MSB_FIRST ? (N - 1 - i) : i) * IN_W +: IN_W] = in_data;
      end
    end
  end

  assign next_count = ins_idx + CW'(1);
  assign full       = (next_count == CW'(N));

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state   <= FILL;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else if (flush) begin
      state   <= FILL;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else if (accept) begin
      data_q  <= ins_data;
      count_q <= next_count;
      state   <= (full || in_last) ? HOLD : FILL;
      last_q  <= in_last & ~full;
    end else if (release_word) begin
      state   <= FILL;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state == HOLD);
  assign out_last  = last_q;
  assign count     = count_q;
  assign state_dbg = state;

endmodule
